// File: rtl/button_request_conditioner_pkg.sv
// Shared types and default timing constants for the pedestrian button conditioner.
package button_request_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_LOCKOUT_CYCLES  = 8;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes the raw button, debounces it and emits a one-cycle press pulse
// on each accepted rising edge of the debounced level.
module button_debouncer
   import button_request_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic button_raw,
   output logic debounced,
   output logic press
);

   // Last count value before the level is allowed to flip.
   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

   logic       sync_1;
   logic       sync_2;
   logic [3:0] stable_cnt;

   // Two-flop synchronizer, stability counter and registered press pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         stable_cnt <= 4'd0;
         debounced  <= 1'b0;
         press      <= 1'b0;
      end else begin
         sync_1 <= button_raw;
         sync_2 <= sync_1;
         press  <= 1'b0;
         if (sync_2 == debounced) begin
            // Any cycle of agreement restarts the stability window.
            stable_cnt <= 4'd0;
         end else if (stable_cnt == DB_LAST) begin
            debounced  <= sync_2;
            stable_cnt <= 4'd0;
            press      <= sync_2;   // only 0->1 transitions are events
         end else begin
            stable_cnt <= stable_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/button_request_conditioner.sv
// Turns a bouncing pedestrian button into a held crossing request with an
// ack handshake, a post-ack lockout window and a saturating press counter.
module button_request_conditioner
   import button_request_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button_raw,
   input  logic       ack,
   output logic       req,
   output logic       busy,
   output logic       debounced,
   output logic [3:0] press_count
);

   localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

   state_t     state;
   state_t     next_state;
   logic       press;
   logic [7:0] lock_cnt;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk        (clk),
      .reset      (reset),
      .button_raw (button_raw),
      .debounced  (debounced),
      .press      (press)
   );

   // Next-state logic; ack outside PENDING and presses outside IDLE are ignored.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (press)              next_state = PENDING;
         PENDING: if (ack)                next_state = LOCKOUT;
         LOCKOUT: if (lock_cnt == 8'd1)   next_state = IDLE;
         default:                         next_state = IDLE;
      endcase
   end

   // State, registered outputs, lockout countdown and saturating press counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         req         <= 1'b0;
         busy        <= 1'b0;
         lock_cnt    <= 8'd0;
         press_count <= 4'd0;
      end else begin
         state <= next_state;
         req   <= (next_state == PENDING);
         busy  <= (next_state == LOCKOUT);
         if (state == PENDING && ack)
            lock_cnt <= LOCK_LOAD;
         else if (state == LOCKOUT && lock_cnt != 8'd0)
            lock_cnt <= lock_cnt - 8'd1;
         if (state == IDLE && press && press_count != 4'd15)
            press_count <= press_count + 4'd1;
      end
   end

endmodule

// File: tb/tb_button_request_conditioner.sv
// Directed bench: a per-cycle vector table for the main handshake, plus
// hand-written sequences for glitches, lockout, saturation and reset.
module tb_button_request_conditioner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       button_raw = 1'b0;
   logic       ack = 1'b0;
   logic       req;
   logic       busy;
   logic       debounced;
   logic [3:0] press_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic rst;
      logic raw;
      logic ak;
      logic e_req;
      logic e_busy;
      logic e_deb;
      int   e_cnt;
   } vec_t;

   vec_t tbl[$];

   button_request_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .LOCKOUT_CYCLES  (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .button_raw  (button_raw),
      .ack         (ack),
      .req         (req),
      .busy        (busy),
      .debounced   (debounced),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic b, input logic a,
                      input logic q, input logic y, input logic d, input int c);
      vec_t v;
      v.rst = r; v.raw = b; v.ak = a;
      v.e_req = q; v.e_busy = y; v.e_deb = d; v.e_cnt = c;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      reset = 1'b1; button_raw = 1'b0; ack = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Wait (bounded) for req to rise.
   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (!req && n < 30) begin
         tick();
         n++;
      end
      check(name, int'(req), 1);
   endtask

   initial begin
      int busy_seen;
      int n;
      // --- vector table: press, ack, lockout, idle ack, release, re-press with ack ---
      add(1,0,0, 0,0,0,0);
      for (int i = 1; i <= 5; i++) add(0,1,0, 0,0,0,0);
      add(0,1,0, 0,0,1,0);                                 // edge 6: debounced
      add(0,1,0, 1,0,1,1);                                 // edge 7: req
      add(0,1,0, 1,0,1,1);
      add(0,1,1, 0,1,1,1);                                 // ack -> lockout
      for (int i = 0; i < 7; i++) add(0,1,0, 0,1,1,1);     // busy 8 cycles total
      add(0,1,0, 0,0,1,1);                                 // back to idle, held button no event
      add(0,1,1, 0,0,1,1);                                 // ack in idle ignored
      for (int i = 0; i < 5; i++) add(0,0,0, 0,0,1,1);
      add(0,0,0, 0,0,0,1);                                 // release debounced
      for (int i = 0; i < 5; i++) add(0,1,0, 0,0,0,1);
      add(0,1,0, 0,0,1,1);
      add(0,1,1, 1,0,1,2);                                 // press + ack same cycle: press wins
      add(0,1,0, 1,0,1,2);

      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst; button_raw = tbl[i].raw; ack = tbl[i].ak;
         tick();
         check($sformatf("tbl[%0d].req", i),  int'(req),         int'(tbl[i].e_req));
         check($sformatf("tbl[%0d].busy", i), int'(busy),        int'(tbl[i].e_busy));
         check($sformatf("tbl[%0d].deb", i),  int'(debounced),   int'(tbl[i].e_deb));
         check($sformatf("tbl[%0d].cnt", i),  int'(press_count), tbl[i].e_cnt);
      end
      ack = 1'b0;

      // --- fast toggling never debounces ---
      do_reset();
      for (int i = 0; i < 30; i++) begin
         button_raw = (i < 20) ? ~button_raw : 1'b0;
         tick();
         check("toggle_deb", int'(debounced), 0);
         check("toggle_req", int'(req), 0);
      end
      check("toggle_cnt", int'(press_count), 0);

      // --- glitch one cycle shorter than the debounce window ---
      do_reset();
      for (int i = 0; i < 12; i++) begin
         button_raw = (i < 3);
         tick();
         check("glitch_deb", int'(debounced), 0);
      end

      // --- ack ends request; busy exactly 8 cycles; press inside lockout discarded ---
      do_reset();
      button_raw = 1'b1;
      wait_req("lk_req");
      button_raw = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("lk_deb_low", int'(debounced), 0);
      check("lk_req_held", int'(req), 1);
      ack = 1'b1; button_raw = 1'b1;
      tick();
      ack = 1'b0;
      check("lk_req_drop", int'(req), 0);
      busy_seen = int'(busy);
      for (int i = 0; i < 14; i++) begin
         tick();
         busy_seen += int'(busy);
         check("lk_no_req", int'(req), 0);
      end
      check("lk_busy_len", busy_seen, 8);
      check("lk_cnt", int'(press_count), 1);
      check("lk_deb_high", int'(debounced), 1);
      button_raw = 1'b0;

      // --- saturation over 16 press/ack/lockout rounds ---
      do_reset();
      for (int r = 1; r <= 16; r++) begin
         button_raw = 1'b1;
         wait_req("sat_req");
         ack = 1'b1;
         tick();
         ack = 1'b0; button_raw = 1'b0;
         check("sat_busy", int'(busy), 1);
         n = 0;
         while ((busy || debounced) && n < 30) begin
            tick();
            n++;
         end
         check("sat_quiet", int'(busy || debounced), 0);
         check($sformatf("sat_cnt[%0d]", r), int'(press_count), (r > 15) ? 15 : r);
      end

      // --- reset mid-lockout drops busy ---
      button_raw = 1'b1;
      wait_req("rl_req");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0; button_raw = 1'b0;
      check("rl_busy", int'(busy), 0);
      check("rl_cnt", int'(press_count), 0);

      // --- reset while pending with button held, then exactly one new request ---
      do_reset();
      button_raw = 1'b1;
      wait_req("rp_req");
      reset = 1'b1;
      tick();
      check("rp_req_drop", int'(req), 0);
      check("rp_deb_drop", int'(debounced), 0);
      reset = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         check($sformatf("rp_edge%0d", e), int'(req), (e == 7) ? 1 : 0);
      end
      for (int i = 0; i < 10; i++) tick();
      check("rp_cnt_once", int'(press_count), 1);
      check("rp_req_hold", int'(req), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/button_request_conditioner.md
BUTTON_REQUEST_CONDITIONER -- requirements
Module: button_request_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before the debounced level changes; legal range 1..15.
REQ-002 Parameter LOCKOUT_CYCLES, default 8: cycles during which presses are ignored after an acknowledged request; legal range 1..255.
REQ-003 Port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port button_raw  input  1  asynchronous, bouncing pedestrian button.
REQ-006 Port ack  input  1  downstream traffic-light FSM has accepted the request.
REQ-007 Port req  output  1  registered crossing request, held until acknowledged.
REQ-008 Port busy  output  1  registered; high while in LOCKOUT.
REQ-009 Port debounced  output  1  registered, debounced button level.
REQ-010 Port press_count  output  4  registered count of accepted requests, saturating.

Function
REQ-011 button_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 debounced SHALL take the synchronized value only after that value has differed from debounced for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears the stability counter.
REQ-013 A press event SHALL be a single-cycle pulse on each 0->1 transition of debounced; 1->0 transitions produce no event.
REQ-014 With button_raw high and stable, debounced SHALL rise after edge DEBOUNCE_CYCLES+2 and req after edge DEBOUNCE_CYCLES+3, counting the first edge that samples button_raw=1 as edge 1.
REQ-015 The FSM SHALL have three states: IDLE, PENDING and LOCKOUT.
REQ-016 IDLE -> PENDING on a press event; req=1 from the next cycle; press_count increments by 1 on the same edge, saturating at 15.
REQ-017 PENDING: req SHALL stay 1 until ack is sampled high; further presses in PENDING are merged (no count, no state change).
REQ-018 PENDING with ack=1 -> LOCKOUT; req=0 and busy=1 from the next cycle; lockout counter loaded with LOCKOUT_CYCLES.
REQ-019 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles (busy high for exactly LOCKOUT_CYCLES cycles), then return to IDLE; presses during LOCKOUT are discarded.
REQ-020 ack sampled in IDLE or LOCKOUT SHALL be ignored.
REQ-021 Press event and ack in the same IDLE cycle: the press wins -> PENDING; the ack is ignored.
REQ-022 A press event on the cycle LOCKOUT exits SHALL be discarded; a press while the button is still held after lockout requires a release and re-press.
REQ-023 Glitches on button_raw shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL NOT change debounced.

Reset
REQ-024 On reset: synchronizer flops, debounced, stability counter, lockout counter, req, busy and press_count SHALL be 0, and the state SHALL be IDLE, all after the same edge.
REQ-025 Reset asserted mid-PENDING or mid-LOCKOUT SHALL drop req/busy on that edge; no request is remembered.
REQ-026 A button held through reset release SHALL produce exactly one press event after the normal debounce latency.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, PENDING, LOCKOUT) and the default DEBOUNCE_CYCLES/LOCKOUT_CYCLES constants.
REQ-028 Synchronizer, debounce and edge detection SHALL live in one sub-module, button_debouncer, which outputs debounced and the press pulse; the FSM, lockout counter and press_count live in the top module.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
REQ-029 Reset, then button_raw=1 stable -> debounced=1 after edge 6, req=1 after edge 7, press_count=1.
REQ-030 button_raw toggles 1,0,1,0 every cycle for 20 cycles, then held at 0 -> debounced, req and press_count remain 0.
REQ-031 req pending; ack pulsed for 1 cycle -> req=0 next cycle; busy=1 for exactly 8 cycles; a clean press inside the lockout -> no req, press_count unchanged.
REQ-032 16 full press/ack/lockout cycles -> press_count reads 15 after the 15th and stays 15 after the 16th.
REQ-033 Reset asserted while req=1 with button held -> req=0 after the reset edge; after release, one new req arrives 7 edges later.
